// File: rtl/sparc_ifu_mthrfsm_pkg.sv
// Shared thread-state encodings (the established 5-bit TCR values) and a
// legality helper used by the per-thread FSM cores and the scheduler.
package sparc_ifu_mthrfsm_pkg;

    localparam int THRFSM_W = 5;

    localparam logic [THRFSM_W-1:0] THRFSM_IDLE     = 5'b00000;
    localparam logic [THRFSM_W-1:0] THRFSM_WAIT     = 5'b00001;
    localparam logic [THRFSM_W-1:0] THRFSM_HALT     = 5'b00010;
    localparam logic [THRFSM_W-1:0] THRFSM_RUN      = 5'b00101;
    localparam logic [THRFSM_W-1:0] THRFSM_SPEC_RUN = 5'b00111;
    localparam logic [THRFSM_W-1:0] THRFSM_SPEC_RDY = 5'b10011;
    localparam logic [THRFSM_W-1:0] THRFSM_RDY      = 5'b11001;

    // True for the seven encoded states; anything else is a corrupted TCR.
    function automatic logic thrfsm_legal(input logic [THRFSM_W-1:0] s);
        logic ok;
        case (s)
            THRFSM_IDLE, THRFSM_WAIT, THRFSM_HALT, THRFSM_RUN,
            THRFSM_SPEC_RUN, THRFSM_SPEC_RDY, THRFSM_RDY: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sparc_ifu_mthrfsm_if.sv
// Per-thread event inputs and thread status outputs of the multi-thread FSM.
// The switch logic drives the master side; the FSM block takes the slave side.
interface sparc_ifu_mthrfsm_if #(
    parameter int N_THR = 4
);
    logic [N_THR-1:0]   completion;
    logic [N_THR-1:0]   spec_ld;
    logic [N_THR-1:0]   ldhit;
    logic [N_THR-1:0]   stall;
    logic [N_THR-1:0]   int_activate;
    logic [N_THR-1:0]   halt_thread;
    logic [N_THR-1:0]   start_thread;
    logic [N_THR-1:0]   nuke_thread;
    logic [N_THR-1:0]   thaw_thread;
    logic [N_THR-1:0]   rst_thread;
    logic               switch_out;
    logic               sw_cond;

    logic [5*N_THR-1:0] thr_state;
    logic [N_THR-1:0]   sched_thr;
    logic [N_THR-1:0]   run_thr;
    logic [N_THR-1:0]   wait_to;
    logic [N_THR-1:0]   illegal_state;

    modport master (
        output completion, spec_ld, ldhit, stall, int_activate, halt_thread,
               start_thread, nuke_thread, thaw_thread, rst_thread,
               switch_out, sw_cond,
        input  thr_state, sched_thr, run_thr, wait_to, illegal_state
    );

    modport slave (
        input  completion, spec_ld, ldhit, stall, int_activate, halt_thread,
               start_thread, nuke_thread, thaw_thread, rst_thread,
               switch_out, sw_cond,
        output thr_state, sched_thr, run_thr, wait_to, illegal_state
    );

endinterface

// File: rtl/sparc_ifu_thrfsm_core.sv
// One hardware thread: TCR state machine, WAIT-duration counter with a single
// timeout pulse per WAIT visit, and an unencoded-state flag.
module sparc_ifu_thrfsm_core
    import sparc_ifu_mthrfsm_pkg::*;
#(
    parameter int TO_W    = 10,
    parameter int WAIT_TO = 512
) (
    input  logic                clk,
    input  logic                arst_l,
    input  logic                completion,
    input  logic                spec_ld,
    input  logic                ldhit,
    input  logic                stall,
    input  logic                int_activate,
    input  logic                halt_thread,
    input  logic                start_thread,
    input  logic                nuke_thread,
    input  logic                thaw_thread,
    input  logic                rst_thread,
    input  logic                sched,
    input  logic                switch_out,
    input  logic                sw_cond,
    output logic [THRFSM_W-1:0] state,
    output logic                running,
    output logic                wait_to,
    output logic                illegal_state
);

    // The counter parks one past the pulse value so the pulse cannot repeat.
    localparam logic [TO_W-1:0] TO_SAT  = TO_W'(WAIT_TO);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((WAIT_TO > 0) ? WAIT_TO - 1 : 0);

    logic [THRFSM_W-1:0] state_reg;
    logic [THRFSM_W-1:0] state_next;
    logic [TO_W-1:0]     cnt_reg;
    logic [TO_W-1:0]     cnt_next;
    logic                run_reg;
    logic                wait_to_reg;
    logic                illegal_reg;
    logic                wait_hit;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            THRFSM_IDLE: begin
                if (rst_thread | thaw_thread)         state_next = THRFSM_WAIT;
                else if (start_thread)                state_next = THRFSM_RDY;
            end
            THRFSM_HALT: begin
                if (nuke_thread)                      state_next = THRFSM_IDLE;
                else if (rst_thread | thaw_thread)    state_next = THRFSM_WAIT;
                else if (int_activate | start_thread) state_next = THRFSM_RDY;
            end
            THRFSM_RDY: begin
                if (stall)                            state_next = THRFSM_WAIT;
                else if (sched)                       state_next = THRFSM_RUN;
            end
            THRFSM_RUN: begin
                if (stall | sw_cond)                  state_next = THRFSM_WAIT;
                else if (switch_out)                  state_next = THRFSM_RDY;
            end
            THRFSM_WAIT: begin
                if (nuke_thread)                      state_next = THRFSM_IDLE;
                else if (halt_thread)                 state_next = THRFSM_HALT;
                else if (stall)                       state_next = THRFSM_WAIT;
                else if (spec_ld)                     state_next = THRFSM_SPEC_RDY;
                else if (completion)                  state_next = THRFSM_RDY;
            end
            THRFSM_SPEC_RDY: begin
                if (stall)                            state_next = THRFSM_WAIT;
                else if (sched & ~ldhit)              state_next = THRFSM_SPEC_RUN;
                else if (sched & ldhit)               state_next = THRFSM_RUN;
                else if (ldhit)                       state_next = THRFSM_RDY;
            end
            THRFSM_SPEC_RUN: begin
                if (stall | sw_cond)                  state_next = THRFSM_WAIT;
                else if (ldhit & switch_out)          state_next = THRFSM_RDY;
                else if (ldhit)                       state_next = THRFSM_RUN;
                else if (switch_out)                  state_next = THRFSM_SPEC_RDY;
            end
            default: begin
                if (rst_thread)                       state_next = THRFSM_WAIT;
                else if (nuke_thread)                 state_next = THRFSM_IDLE;
            end
        endcase
    end

    // Counter value in a cycle equals the number of earlier consecutive WAIT cycles.
    always_comb begin
        cnt_next = '0;
        if (state_next == THRFSM_WAIT && state_reg == THRFSM_WAIT) begin
            cnt_next = (cnt_reg == TO_SAT) ? cnt_reg : cnt_reg + TO_W'(1);
        end
    end

    assign wait_hit = (WAIT_TO != 0) && (state_next == THRFSM_WAIT) && (cnt_next == TO_LAST);

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            state_reg   <= THRFSM_IDLE;
            cnt_reg     <= '0;
            run_reg     <= 1'b0;
            wait_to_reg <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            run_reg     <= (state_next == THRFSM_RUN) || (state_next == THRFSM_SPEC_RUN);
            wait_to_reg <= wait_hit;
            illegal_reg <= !thrfsm_legal(state_next);
        end
    end

    assign state         = state_reg;
    assign running       = run_reg;
    assign wait_to       = wait_to_reg;
    assign illegal_state = illegal_reg;

endmodule

// File: rtl/sparc_ifu_mthrfsm.sv
// N_THR thread state machines plus a round-robin switch scheduler that issues
// at most one ready thread per cycle, and only while no thread is running.
module sparc_ifu_mthrfsm
    import sparc_ifu_mthrfsm_pkg::*;
#(
    parameter int N_THR   = 4,
    parameter int TO_W    = 10,
    parameter int WAIT_TO = 512
) (
    input  logic                 clk,
    input  logic                 arst_l,
    sparc_ifu_mthrfsm_if.slave   bus
);

    localparam int PTR_W = $clog2(N_THR);

    logic [THRFSM_W-1:0] thr_st [N_THR];
    logic [N_THR-1:0]    cand_rdy;
    logic [N_THR-1:0]    cand_spec;
    logic [N_THR-1:0]    sched;
    logic [N_THR-1:0]    run_vec;
    logic [PTR_W-1:0]    ptr_reg;
    logic [PTR_W-1:0]    ptr_next;
    logic [PTR_W-1:0]    pick_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_THR; gi++) begin : g_thr
            sparc_ifu_thrfsm_core #(
                .TO_W    (TO_W),
                .WAIT_TO (WAIT_TO)
            ) u_core (
                .clk           (clk),
                .arst_l        (arst_l),
                .completion    (bus.completion[gi]),
                .spec_ld       (bus.spec_ld[gi]),
                .ldhit         (bus.ldhit[gi]),
                .stall         (bus.stall[gi]),
                .int_activate  (bus.int_activate[gi]),
                .halt_thread   (bus.halt_thread[gi]),
                .start_thread  (bus.start_thread[gi]),
                .nuke_thread   (bus.nuke_thread[gi]),
                .thaw_thread   (bus.thaw_thread[gi]),
                .rst_thread    (bus.rst_thread[gi]),
                .sched         (sched[gi]),
                .switch_out    (bus.switch_out),
                .sw_cond       (bus.sw_cond),
                .state         (thr_st[gi]),
                .running       (run_vec[gi]),
                .wait_to       (bus.wait_to[gi]),
                .illegal_state (bus.illegal_state[gi])
            );

            assign bus.thr_state[THRFSM_W*gi +: THRFSM_W] = thr_st[gi];

            // A thread stalled this cycle is heading to WAIT, so it is never picked.
            assign cand_rdy[gi]  = (thr_st[gi] == THRFSM_RDY)      & ~bus.stall[gi];
            assign cand_spec[gi] = (thr_st[gi] == THRFSM_SPEC_RDY) & ~bus.stall[gi];
        end
    endgenerate

    // First requester at or after start, wrapping modulo N_THR.
    function automatic logic [N_THR-1:0] rr_pick(input logic [N_THR-1:0] req,
                                                 input logic [PTR_W-1:0] start);
        logic [N_THR-1:0] grant;
        logic [PTR_W:0]   idx;
        logic             found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N_THR; k++) begin
            idx = {1'b0, start} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(N_THR)) begin
                idx = idx - (PTR_W+1)'(N_THR);
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
        return grant;
    endfunction

    // run_vec is registered, so a thread leaving RUN still blocks this cycle.
    always_comb begin
        sched = '0;
        if (run_vec == '0) begin
            if (cand_rdy != '0) begin
                sched = rr_pick(cand_rdy, ptr_reg);
            end else begin
                sched = rr_pick(cand_spec, ptr_reg);
            end
        end
    end

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N_THR; k++) begin
            if (sched[k]) begin
                pick_idx = PTR_W'(k);
            end
        end
    end

    assign ptr_next = (pick_idx == PTR_W'(N_THR - 1)) ? '0 : pick_idx + PTR_W'(1);

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            ptr_reg <= '0;
        end else if (sched != '0) begin
            ptr_reg <= ptr_next;
        end
    end

    assign bus.sched_thr = sched;
    assign bus.run_thr   = run_vec;

endmodule
